// File: rtl/cia_pipe_adder_pkg.sv
// Shared ALU definitions: carry-increment group width, group-count helper and
// the result-flag bundle consumed by the ALU result mux.
package cia_pipe_adder_pkg;

  localparam int GRP_W = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } res_flags_t;

  function automatic int num_groups(input int width);
    return width / GRP_W;
  endfunction

endpackage

// File: rtl/cia_grp_incr.sv
// 4-bit group incrementer: adds the resolved group carry-in to a raw group sum.
module cia_grp_incr (
  input  logic [3:0] val_i,
  input  logic       inc_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  assign {carry_o, sum_o} = {1'b0, val_i} + {4'b0000, inc_i};

endmodule

// File: rtl/cia_pipe_adder.sv
// Two-stage pipelined carry-increment adder: stage 1 forms raw group sums,
// stage 2 resolves the group carry chain and increments each group.
module cia_pipe_adder
  import cia_pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int G = num_groups(WIDTH);

  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [G-1:0]     k_q, k_d;
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  res_flags_t       flags_q, flags_d;
  logic [G:0]       c;
  logic [G-1:0]     inc_carry;
  logic             adv1, adv2;

  assign adv2     = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | adv2;
  assign adv1     = in_valid & in_ready;

  // cin is folded into group 0 in stage 1, so the stage-2 chain starts at 0.
  assign c[0] = 1'b0;

  genvar g;
  generate
    for (g = 0; g < G; g++) begin : g_grp
      logic [GRP_W:0] r;

      assign r = {1'b0, a[GRP_W*g +: GRP_W]} + {1'b0, b[GRP_W*g +: GRP_W]}
               + ((g == 0) ? {4'b0000, cin} : 5'b00000);
      assign s0_d[GRP_W*g +: GRP_W] = r[GRP_W-1:0];
      assign k_d[g]                 = r[GRP_W];

      cia_grp_incr u_incr (
        .val_i  (s0_q[GRP_W*g +: GRP_W]),
        .inc_i  (c[g]),
        .sum_o  (sum_d[GRP_W*g +: GRP_W]),
        .carry_o(inc_carry[g])
      );

      // Generate and increment-carry are mutually exclusive, so OR is exact.
      assign c[g+1] = k_q[g] | inc_carry[g];
    end
  endgenerate

  always_comb begin
    flags_d      = '0;
    flags_d.cout = c[G];
    flags_d.ovf  = (a_msb_q == b_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
    flags_d.zero = ~|sum_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s0_q       <= '0;
      k_q        <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      sum_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= adv1 | (s1_valid_q & ~adv2);
      if (adv1) begin
        s0_q    <= s0_d;
        k_q     <= k_d;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (adv2) begin
        s2_valid_q <= 1'b1;
        sum_q      <= sum_d;
        flags_q    <= flags_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_cia_pipe_adder.sv
// Self-checking bench for cia_pipe_adder: directed corner cases plus a
// randomized run scored against an arithmetic reference model.
module tb_cia_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout, ovf, zero;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;

  logic [34:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [34:0] held = '0;

  cia_pipe_adder #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // {cout, ovf, zero, sum} straight from integer arithmetic.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] f;
    logic [31:0] s;
    f = {1'b0, x} + {1'b0, y} + {32'd0, c};
    s = f[31:0];
    return {f[32], (x[31] == y[31]) && (s[31] != x[31]), s == 32'd0, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: score handshakes for the currently driven inputs, then
  // advance to the next falling edge.
  task automatic cyc();
    logic [34:0] got;
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin));
      n_acc++;
    end
    if (out_valid === 1'b1) begin
      got = {cout, ovf, zero, sum};
      if (held_v) check("stall_hold", got, held);
      if (out_ready) begin
        n_out++;
        check("out_has_model_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("result", got, exp_q.pop_front());
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held   = got;
      end
    end else begin
      held_v = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dir_beat(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input logic ci, input logic [34:0] expv);
    in_valid  = 1'b1;
    a         = aa;
    b         = bb;
    cin       = ci;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, out_valid, 0);
    cyc();
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_value"}, {cout, ovf, zero, sum}, expv);
    cyc();
  endtask

  initial begin
    logic [31:0] ba[4];
    logic [31:0] bb[4];
    logic        bc[4];
    int          sent, out0, acc0, cycles;

    // Reset
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {cout, ovf, zero, sum}, 0);
    @(negedge clk);

    // Directed arithmetic corners with latency checks
    dir_beat("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    dir_beat("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    dir_beat("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 1'b1, 32'h0000_0000});
    dir_beat("skip", 32'h0FFF_FFF0, 32'h0000_0010, 1'b0, {1'b0, 1'b0, 1'b0, 32'h1000_0000});

    // Full throughput with out_ready held high
    acc0      = n_acc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0;
    check("throughput_accepts", n_acc - acc0, 6);
    for (int i = 0; i < 4; i++) cyc();

    // Backpressure: 4 beats offered, downstream stalled for 5 cycles
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom; bb[i] = $urandom; bc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    out0 = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (sent < 4);
      if (sent < 4) begin a = ba[sent]; b = bb[sent]; cin = bc[sent]; end
      #1;
      check("bp_in_ready", in_ready, (i < 2) ? 1 : 0);
      if (in_valid && in_ready) sent++;
      cyc();
    end
    out_ready = 1'b1;
    in_valid  = (sent < 4);
    if (sent < 4) begin a = ba[sent]; b = bb[sent]; cin = bc[sent]; end
    #1;
    check("full_pipe_simul_in_ready", in_ready, 1);
    cycles = 0;
    while ((sent < 4 || exp_q.size() != 0) && cycles < 20) begin
      in_valid = (sent < 4);
      if (sent < 4) begin a = ba[sent]; b = bb[sent]; cin = bc[sent]; end
      #1;
      if (in_valid && in_ready) sent++;
      cyc();
      cycles++;
    end
    in_valid = 1'b0;
    check("bp_results_count", n_out - out0, 4);

    // Reset while both stages hold beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = $urandom; b = $urandom; cin = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    #1;
    check("pre_rst_full_out_valid", out_valid, 1);
    check("pre_rst_full_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    held_v = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_outputs", {cout, ovf, zero, sum}, 0);
    @(negedge clk);
    out_ready = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 5; i++) cyc();
    check("midrst_no_stale", n_out - out0, 0);

    // Randomized traffic with random backpressure
    acc0   = n_acc;
    cycles = 0;
    while ((n_acc - acc0) < 10000 && cycles < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = ~a;
        1: begin a = 32'hFFFF_FFFF; b = {31'd0, 1'($urandom_range(0, 1))}; end
        default: b = $urandom;
      endcase
      cin = 1'($urandom_range(0, 1));
      cyc();
      cycles++;
    end
    in_valid = 1'b0;
    check("rand_accept_count", n_acc - acc0, 10000);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    check("rand_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
